life_gen_sequencer: RTL and testbench
=====================================

Name: life_gen_sequencer

Overview:
- Controller for the 8x8 Game-of-Life datapath: decides when the 64-bit grid register loads and which source it loads from (fixed pattern, LFSR, next generation).
- Paces generations with a tick prescaler and supports run, pause and single-step.
- Counts generations and auto-halts on still-life or extinction.
- Sits between the debounced button pulses and the grid flop / LFSR / evolve datapath.

Parameters:
- TICK_DIV, 50_000_000: cycles spent in RUN between commits; legal range ≥1.
- GEN_W, 16: generation counter width.
- AUTO_HALT, 1: 1 enables halting on still-life or extinction; 0 disables it.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- run_req  in  1  single-cycle pulse: start free-running.
- pause_req  in  1  single-cycle pulse: stop after any in-flight commit.
- step_req  in  1  single-cycle pulse: advance exactly one generation.
- rand_req  in  1  single-cycle pulse: load grid from LFSR.
- clear_req  in  1  single-cycle pulse: load fixed pattern.
- grid_cur  in  64  current grid register value.
- grid_next  in  64  combinational evolve-datapath result.
- grid_we  out  1  grid register load enable.
- seed_sel  out  2  grid mux select: 00 hold, 01 fixed, 10 LFSR, 11 next.
- lfsr_adv  out  1  advance LFSR by one step.
- gen_count  out  GEN_W  generations committed since last load.
- busy  out  1  high in RUN or COMMIT.
- halted_stable  out  1  sticky still-life flag.
- halted_empty  out  1  sticky extinction flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=LOADF, tick=0, gen_count=0.
  - Both flags 0, grid_we=0, seed_sel=00, lfsr_adv=0.
  - All outputs are forced to these values immediately, including mid-run.
- Outputs are Moore, decoded from state:
  - LOADF: grid_we=1, seed_sel=01.
  - LOADR: grid_we=1, seed_sel=10, lfsr_adv=1.
  - COMMIT: grid_we=1, seed_sel=11.
  - All other states: grid_we=0, seed_sel=00, lfsr_adv=0.
- States: LOADF, LOADR, IDLE, RUN, COMMIT, HALT.
- Command priority (same cycle): clear > rand > pause > step > run. Lower-priority pulses in that cycle are dropped.
- LOADF, LOADR:
  - Clear gen_count and both flags, then go to IDLE.
  - The first cycle after reset release is LOADF.
- IDLE:
  - clear→LOADF, rand→LOADR.
  - step→COMMIT with single=1.
  - run→RUN with tick=0.
  - pause ignored.
- RUN:
  - tick increments every cycle.
  - At tick==TICK_DIV-1: tick←0, go to COMMIT with single=0.
  - Commit period is TICK_DIV+1 cycles.
  - pause→IDLE, clear→LOADF, rand→LOADR (tick←0 on exit).
  - step and run ignored.
- COMMIT (exactly one cycle; any request arriving this cycle still lets the commit finish):
  - If AUTO_HALT and grid_next==0: set halted_empty, gen_count+1, go to HALT. Empty is checked first, so an all-zero grid sets halted_empty only.
  - Else if AUTO_HALT and grid_next==grid_cur: set halted_stable, gen_count unchanged, go to HALT.
  - Otherwise gen_count+1 (wraps modulo 2^GEN_W).
  - Next state: clear→LOADF; rand→LOADR; pause or single=1→IDLE; otherwise RUN with tick=0.
- HALT:
  - Exit only via clear→LOADF or rand→LOADR.
  - run, step and pause are ignored.
  - Flags stay set until the next load.
- Latency:
  - A request pulse sampled at edge k enters its target state in cycle k+1.
  - The grid register updates at edge k+2.
- busy = (state==RUN)|(state==COMMIT).

Decomposition:
- Package life_pkg holds:
  - state enum (LOADF, LOADR, IDLE, RUN, COMMIT, HALT).
  - Seed-select constants SEL_HOLD=2'b00, SEL_FIXED=2'b01, SEL_LFSR=2'b10, SEL_NEXT=2'b11.
  - FIXED_PATTERN=64'h00000000_E0000000 (blinker).
  - GRID_W=64.
- One sub-module, life_tick_prescaler:
  - Parameter TICK_DIV; inputs clk, reset, clr, en; output term.
  - Counts while en, clears on clr, asserts term when count==TICK_DIV-1.

Test Plan:
- Reset release → one cycle with grid_we=1, seed_sel=01, gen_count=0; then IDLE with grid_we=0.
- IDLE, grid_cur=64'h00000000_E0000000, grid_next=64'h00004000_40004000; pulse step_req → one cycle of grid_we=1, seed_sel=11; gen_count=1; back to IDLE, busy=0.
- TICK_DIV=4, non-stable grids, pulse run_req → grid_we pulses every 5 cycles; pause_req after the 3rd pulse → gen_count=3, no further pulses. GEN_W=2 with 4 commits → gen_count=0.
- In RUN, drive grid_next==grid_cur=64'h00000000_18180000 → commit; halted_stable=1, HALT, gen_count unchanged; run_req and step_req ignored; rand_req → LOADR (seed_sel=10, lfsr_adv=1), halted_stable=0, gen_count=0.
- In RUN, drive grid_next=0 → halted_empty=1, halted_stable=0, HALT. Repeat with AUTO_HALT=0 → stays in RUN.
- clear_req and rand_req in the same IDLE cycle → LOADF (seed_sel=01), lfsr_adv stays 0. Drive reset=0 mid-RUN → grid_we, busy and gen_count go to 0 before the next clk edge.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and constants for the 8x8 Game-of-Life controller slice.
package life_pkg;

  localparam int GRID_W = 64;

  typedef enum logic [2:0] {
    ST_LOADF  = 3'd0,
    ST_LOADR  = 3'd1,
    ST_IDLE   = 3'd2,
    ST_RUN    = 3'd3,
    ST_COMMIT = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_FIXED = 2'b01;
  localparam logic [1:0] SEL_LFSR  = 2'b10;
  localparam logic [1:0] SEL_NEXT  = 2'b11;

  // Blinker, the pattern loaded on clear.
  localparam logic [GRID_W-1:0] FIXED_PATTERN = 64'h00000000_E0000000;

endpackage

// File: rtl/life_tick_prescaler.sv
// Free-running tick counter that flags the last cycle of each TICK_DIV-cycle interval.
module life_tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign term = en && (count_q == LAST);

endmodule

// File: rtl/life_gen_sequencer.sv
// Run/pause/step controller deciding when and from where the Life grid register loads.
module life_gen_sequencer
  import life_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int GEN_W     = 16,
  parameter int AUTO_HALT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_req,
  input  logic              pause_req,
  input  logic              step_req,
  input  logic              rand_req,
  input  logic              clear_req,
  input  logic [GRID_W-1:0] grid_cur,
  input  logic [GRID_W-1:0] grid_next,
  output logic              grid_we,
  output logic [1:0]        seed_sel,
  output logic              lfsr_adv,
  output logic [GEN_W-1:0]  gen_count,
  output logic              busy,
  output logic              halted_stable,
  output logic              halted_empty
);

  state_e             state_q, state_d;
  logic               single_q, single_d;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic               stable_q, stable_d;
  logic               empty_q, empty_d;
  logic               halt_now;
  logic               tick_term;
  logic               in_run;

  assign in_run = (state_q == ST_RUN);

  life_tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (!in_run),
    .en   (in_run),
    .term (tick_term)
  );

  always_comb begin
    state_d  = state_q;
    single_d = single_q;
    gen_d    = gen_q;
    stable_d = stable_q;
    empty_d  = empty_q;
    halt_now = 1'b0;
    case (state_q)
      ST_LOADF, ST_LOADR: begin
        gen_d    = '0;
        stable_d = 1'b0;
        empty_d  = 1'b0;
        state_d  = ST_IDLE;
      end
      ST_IDLE: begin
        if (clear_req)      state_d = ST_LOADF;
        else if (rand_req)  state_d = ST_LOADR;
        else if (pause_req) state_d = ST_IDLE;
        else if (step_req) begin
          state_d  = ST_COMMIT;
          single_d = 1'b1;
        end else if (run_req) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (clear_req)      state_d = ST_LOADF;
        else if (rand_req)  state_d = ST_LOADR;
        else if (pause_req) state_d = ST_IDLE;
        else if (tick_term) begin
          state_d  = ST_COMMIT;
          single_d = 1'b0;
        end
      end
      ST_COMMIT: begin
        // Extinction wins over still-life so an empty grid reports only halted_empty.
        if ((AUTO_HALT != 0) && (grid_next == '0)) begin
          empty_d  = 1'b1;
          gen_d    = gen_q + GEN_W'(1);
          halt_now = 1'b1;
        end else if ((AUTO_HALT != 0) && (grid_next == grid_cur)) begin
          stable_d = 1'b1;
          halt_now = 1'b1;
        end else begin
          gen_d = gen_q + GEN_W'(1);
        end
        if (clear_req)                  state_d = ST_LOADF;
        else if (rand_req)              state_d = ST_LOADR;
        else if (halt_now)              state_d = ST_HALT;
        else if (pause_req || single_q) state_d = ST_IDLE;
        else                            state_d = ST_RUN;
      end
      ST_HALT: begin
        if (clear_req)     state_d = ST_LOADF;
        else if (rand_req) state_d = ST_LOADR;
      end
      default: state_d = ST_LOADF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_LOADF;
      single_q <= 1'b0;
      gen_q    <= '0;
      stable_q <= 1'b0;
      empty_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      single_q <= single_d;
      gen_q    <= gen_d;
      stable_q <= stable_d;
      empty_q  <= empty_d;
    end
  end

  // The reset state is LOADF, so load strobes are masked until reset releases.
  always_comb begin
    grid_we  = 1'b0;
    seed_sel = SEL_HOLD;
    lfsr_adv = 1'b0;
    if (reset) begin
      case (state_q)
        ST_LOADF: begin
          grid_we  = 1'b1;
          seed_sel = SEL_FIXED;
        end
        ST_LOADR: begin
          grid_we  = 1'b1;
          seed_sel = SEL_LFSR;
          lfsr_adv = 1'b1;
        end
        ST_COMMIT: begin
          grid_we  = 1'b1;
          seed_sel = SEL_NEXT;
        end
        default: begin
          grid_we  = 1'b0;
          seed_sel = SEL_HOLD;
          lfsr_adv = 1'b0;
        end
      endcase
    end
  end

  assign busy          = (state_q == ST_RUN) || (state_q == ST_COMMIT);
  assign gen_count     = gen_q;
  assign halted_stable = stable_q;
  assign halted_empty  = empty_q;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Directed bench: instance A auto-halts with 16-bit count, instance B never halts and wraps at 2 bits.
module tb_life_gen_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_req, pause_req, step_req, rand_req, clear_req;
  logic [63:0] grid_cur, grid_next;

  logic        a_grid_we, a_lfsr_adv, a_busy, a_halted_stable, a_halted_empty;
  logic [1:0]  a_seed_sel;
  logic [15:0] a_gen_count;
  logic        b_grid_we, b_lfsr_adv, b_busy, b_halted_stable, b_halted_empty;
  logic [1:0]  b_seed_sel;
  logic [1:0]  b_gen_count;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  life_gen_sequencer #(.TICK_DIV(4), .GEN_W(16), .AUTO_HALT(1)) dut_a (
    .clk(clk), .reset(reset),
    .run_req(run_req), .pause_req(pause_req), .step_req(step_req),
    .rand_req(rand_req), .clear_req(clear_req),
    .grid_cur(grid_cur), .grid_next(grid_next),
    .grid_we(a_grid_we), .seed_sel(a_seed_sel), .lfsr_adv(a_lfsr_adv),
    .gen_count(a_gen_count), .busy(a_busy),
    .halted_stable(a_halted_stable), .halted_empty(a_halted_empty)
  );

  life_gen_sequencer #(.TICK_DIV(4), .GEN_W(2), .AUTO_HALT(0)) dut_b (
    .clk(clk), .reset(reset),
    .run_req(run_req), .pause_req(pause_req), .step_req(step_req),
    .rand_req(rand_req), .clear_req(clear_req),
    .grid_cur(grid_cur), .grid_next(grid_next),
    .grid_we(b_grid_we), .seed_sel(b_seed_sel), .lfsr_adv(b_lfsr_adv),
    .gen_count(b_gen_count), .busy(b_busy),
    .halted_stable(b_halted_stable), .halted_empty(b_halted_empty)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // reqs = {clear, rand, pause, step, run}, held for exactly one sampling edge.
  task automatic applyStimulus(input logic [4:0] reqs);
    {clear_req, rand_req, pause_req, step_req, run_req} = reqs;
    nextCycle();
    {clear_req, rand_req, pause_req, step_req, run_req} = 5'b0;
  endtask

  initial begin
    int p [3];
    int np;
    int extra;

    reset = 1'b0;
    {clear_req, rand_req, pause_req, step_req, run_req} = 5'b0;
    grid_cur  = 64'h00000000_E0000000;
    grid_next = 64'h00004000_40004000;

    repeat (2) nextCycle();
    checkOutput("rst_grid_we", a_grid_we, 0);
    checkOutput("rst_seed_sel", a_seed_sel, 0);
    checkOutput("rst_gen", a_gen_count, 0);

    reset = 1'b1;
    #1;
    checkOutput("loadf_grid_we", a_grid_we, 1);
    checkOutput("loadf_seed_sel", a_seed_sel, 2'b01);
    checkOutput("loadf_lfsr_adv", a_lfsr_adv, 0);
    nextCycle();
    checkOutput("idle_grid_we", a_grid_we, 0);
    checkOutput("idle_seed_sel", a_seed_sel, 0);

    applyStimulus(5'b00010);
    checkOutput("step_grid_we", a_grid_we, 1);
    checkOutput("step_seed_sel", a_seed_sel, 2'b11);
    checkOutput("step_busy", a_busy, 1);
    nextCycle();
    checkOutput("step_gen", a_gen_count, 1);
    checkOutput("step_idle_busy", a_busy, 0);
    checkOutput("step_idle_we", a_grid_we, 0);

    applyStimulus(5'b10000);
    nextCycle();
    checkOutput("clear_gen", a_gen_count, 0);

    // Free run: commits expected in cycles 5, 10 and 15 after entering RUN.
    applyStimulus(5'b00001);
    p = '{0, 0, 0};
    np = 0;
    for (int i = 1; i <= 15; i++) begin
      if (i > 1) nextCycle();
      if (a_grid_we) begin
        if (np < 3) p[np] = i;
        np++;
      end
      if (i == 15) pause_req = 1'b1;
    end
    nextCycle();
    pause_req = 1'b0;
    checkOutput("run_pulse_count", np, 3);
    checkOutput("run_pulse1", p[0], 5);
    checkOutput("run_pulse2", p[1], 10);
    checkOutput("run_pulse3", p[2], 15);
    checkOutput("pause_gen", a_gen_count, 3);
    checkOutput("pause_busy", a_busy, 0);
    checkOutput("b_gen3", b_gen_count, 3);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      if (a_grid_we) extra++;
    end
    checkOutput("paused_no_pulses", extra, 0);

    applyStimulus(5'b00010);
    nextCycle();
    checkOutput("gen4", a_gen_count, 4);
    checkOutput("b_gen_wrap", b_gen_count, 0);

    // Still life.
    grid_cur  = 64'h00000000_18180000;
    grid_next = 64'h00000000_18180000;
    applyStimulus(5'b00001);
    repeat (4) nextCycle();
    checkOutput("stable_commit_we", a_grid_we, 1);
    nextCycle();
    checkOutput("stable_flag", a_halted_stable, 1);
    checkOutput("stable_gen", a_gen_count, 4);
    checkOutput("stable_busy", a_busy, 0);
    checkOutput("b_stable_busy", b_busy, 1);
    checkOutput("b_stable_gen", b_gen_count, 1);
    applyStimulus(5'b00001);
    checkOutput("halt_run_busy", a_busy, 0);
    applyStimulus(5'b00010);
    checkOutput("halt_step_we", a_grid_we, 0);
    checkOutput("halt_flag_kept", a_halted_stable, 1);
    applyStimulus(5'b01000);
    checkOutput("loadr_seed_sel", a_seed_sel, 2'b10);
    checkOutput("loadr_lfsr_adv", a_lfsr_adv, 1);
    checkOutput("loadr_grid_we", a_grid_we, 1);
    nextCycle();
    checkOutput("loadr_flag_clr", a_halted_stable, 0);
    checkOutput("loadr_gen_clr", a_gen_count, 0);

    // Extinction.
    grid_cur  = 64'h00000000_E0000000;
    grid_next = 64'h0;
    applyStimulus(5'b00001);
    repeat (4) nextCycle();
    nextCycle();
    checkOutput("empty_flag", a_halted_empty, 1);
    checkOutput("empty_no_stable", a_halted_stable, 0);
    checkOutput("empty_busy", a_busy, 0);
    checkOutput("empty_gen", a_gen_count, 1);
    checkOutput("b_empty_busy", b_busy, 1);
    checkOutput("b_empty_flag", b_halted_empty, 0);

    // Clear beats rand in the same cycle.
    grid_next = 64'h00004000_40004000;
    applyStimulus(5'b10000);
    nextCycle();
    applyStimulus(5'b11000);
    checkOutput("prio_seed_sel", a_seed_sel, 2'b01);
    checkOutput("prio_lfsr_adv", a_lfsr_adv, 0);
    nextCycle();

    // Asynchronous reset during the second commit of a run.
    applyStimulus(5'b00001);
    repeat (9) nextCycle();
    checkOutput("midrun_commit_we", a_grid_we, 1);
    checkOutput("midrun_gen", a_gen_count, 1);
    reset = 1'b0;
    #1;
    checkOutput("async_grid_we", a_grid_we, 0);
    checkOutput("async_busy", a_busy, 0);
    checkOutput("async_gen", a_gen_count, 0);
    checkOutput("async_seed_sel", a_seed_sel, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
